// File: rtl/cdc_handshake_rx_pkg.sv
// Shared definitions for the receive side of the req/ack bus crossing.
package cdc_handshake_rx_pkg;

  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_BUS_WIDTH  = 8;

  // Encoding 2'b11 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VALID = 2'b01,
    ST_ACK   = 2'b10
  } rx_state_e;

endpackage

// File: rtl/cdc_handshake_rx_req_chain.sv
// Multi-flop level synchronizer. The transmit-side controller reuses it for ack.
module cdc_handshake_rx_req_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_sync
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  // Shift the asynchronous level in at stage 0; the last stage is the safe output.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d_async};
  end

  // Chain registers, cleared asynchronously so req_s reads low out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_sync = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Destination-side 4-phase req/ack controller: captures the quasi-static source
// bus once per request, offers it with valid/ready, and returns a level ack.
//
// state | meaning
// IDLE  | waiting for synchronized req high; ack low
// VALID | word captured and offered to the consumer; ack low
// ACK   | word consumed, ack high until synchronized req drops
module cdc_handshake_rx
  import cdc_handshake_rx_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_async,
  input  logic [BUS_WIDTH-1:0] data_async,
  output logic                 ack,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 proto_err
);

  logic                 req_s;
  rx_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  // Only req crosses through a synchronizer; data_async is sampled once when the
  // synchronized req is seen, relying on the source holding it stable.
  cdc_handshake_rx_req_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_req_chain (
    .clk     (clk),
    .rst_n   (rst),
    .d_async (req_async),
    .q_sync  (req_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          data_d  = data_async;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // Source dropped req before seeing ack: flag it but still deliver the word.
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset mid-transfer discards the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign proto_err = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
